// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// rtl/ofs_fim_pcie_ss_shims_pkg.sv - shared types and helpers for the PCIe SS shims
//
// Purpose : side-band tuser segment type, tuser vector width helper,
//           TX arbiter weight type, arbiter state encoding and the
//           weighted-round-robin scan function.
// Ports   : none (package).
package ofs_fim_pcie_ss_shims_pkg;

  // One side-band header segment as carried on tuser.
  typedef struct packed {
    logic         vendor_msg;
    logic         hvalid;
    logic         last_segment;
    logic [255:0] hdr;
  } t_tuser_seg;

  localparam int TUSER_SEG_W = $bits(t_tuser_seg);

  // Width of a t_tuser_seg vector with num_seg entries; modules build the
  // actual vector typedef locally from their own NUM_OF_SEG.
  function automatic int tuser_seg_vec_width(input int num_seg);
    return num_seg * TUSER_SEG_W;
  endfunction

  localparam int TX_ARB_WEIGHT_W = 4;
  typedef logic [TX_ARB_WEIGHT_W-1:0] t_tx_arb_weight;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } t_arb_state;

  // First set bit of valid_mask scanning ptr+1, ptr+2, ... modulo num_ch.
  // ptr itself is visited last. Returns -1 when no bit is set.
  function automatic int next_eligible(input logic [15:0] valid_mask,
                                       input int          ptr,
                                       input int          num_ch);
    int found;
    int idx;
    found = -1;
    for (int i = 1; i <= 16; i++) begin
      idx = ptr + i;
      if (idx >= num_ch) idx = idx - num_ch;
      if (found < 0 && i <= num_ch && valid_mask[idx[3:0]]) found = idx;
    end
    return found;
  endfunction

endpackage

// File: rtl/ofs_fim_pcie_ss_tx_arb_skid.sv
// rtl/ofs_fim_pcie_ss_tx_arb_skid.sv - 2-entry registered skid buffer
//
// Purpose : decouples the arbiter from downstream backpressure. Both the
//           input ready and the output valid/data come straight from flops.
// Ports   : i_clk, i_rst_n              clock, async active-low reset
//           i_tvalid/o_tready/i_tdata   upstream beat (PAYLOAD_W bits)
//           o_tvalid/i_tready/o_tdata   downstream beat
module ofs_fim_pcie_ss_tx_arb_skid #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tvalid,
  output logic                 o_tready,
  input  logic [PAYLOAD_W-1:0] i_tdata,
  output logic                 o_tvalid,
  input  logic                 i_tready,
  output logic [PAYLOAD_W-1:0] o_tdata
);

  logic [PAYLOAD_W-1:0] r_mem [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;
  logic                 r_ready;
  logic                 w_push;
  logic                 w_pop;
  logic [1:0]           w_count_nxt;

  assign w_push      = i_tvalid & r_ready;
  assign w_pop       = (r_count != 2'd0) & i_tready;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
      // Ready reflects next-cycle occupancy so it never sees i_tready combinationally.
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_tdata;
  end

  assign o_tready = r_ready;
  assign o_tvalid = (r_count != 2'd0);
  assign o_tdata  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ofs_fim_pcie_ss_tx_arb.sv
// rtl/ofs_fim_pcie_ss_tx_arb.sv - packet-atomic weighted round-robin TX stream merge
//
// Purpose : merges NUM_CH side-band-header TX streams into one PCIe SS TX
//           stream. Packets are never interleaved; each channel gets up to
//           ch_weight packets per turn; weight 0 masks a channel.
// Build   : define OFS_FIM_PCIE_SS_TX_ARB_STATS_EN to build per-channel
//           packet counters on o_pkt_cnt; otherwise o_pkt_cnt is tied to 0.
// Ports   : i_hip_clk, i_hip_rst_n           clock, async active-low reset
//           i_in_tvalid/o_in_tready/i_in_tdata/i_in_tkeep/i_in_tlast/i_in_tuser
//                                            per-channel input streams
//           i_ch_weight                      per-channel packets per turn
//           o_out_tvalid/i_out_tready/o_out_tdata/o_out_tkeep/o_out_tlast/o_out_tuser
//                                            merged output stream
//           o_pkt_cnt                        per-channel accepted packet count
module ofs_fim_pcie_ss_tx_arb #(
  parameter int NUM_CH      = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int NUM_OF_SEG  = 1,
  parameter int WEIGHT_W    = 4,
  localparam int TUSER_W    = ofs_fim_pcie_ss_shims_pkg::tuser_seg_vec_width(NUM_OF_SEG)
) (
  input  logic                      i_hip_clk,
  input  logic                      i_hip_rst_n,
  input  logic [NUM_CH-1:0]         i_in_tvalid,
  output logic [NUM_CH-1:0]         o_in_tready,
  input  logic [NUM_CH*TDATA_WIDTH-1:0] i_in_tdata,
  input  logic [NUM_CH*TKEEP_WIDTH-1:0] i_in_tkeep,
  input  logic [NUM_CH-1:0]         i_in_tlast,
  input  logic [NUM_CH*TUSER_W-1:0] i_in_tuser,
  input  logic [NUM_CH*WEIGHT_W-1:0] i_ch_weight,
  output logic                      o_out_tvalid,
  input  logic                      i_out_tready,
  output logic [TDATA_WIDTH-1:0]    o_out_tdata,
  output logic [TKEEP_WIDTH-1:0]    o_out_tkeep,
  output logic                      o_out_tlast,
  output logic [TUSER_W-1:0]        o_out_tuser,
  output logic [NUM_CH*32-1:0]      o_pkt_cnt
);
  import ofs_fim_pcie_ss_shims_pkg::*;

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = TUSER_W + 1 + TKEEP_WIDTH + TDATA_WIDTH;

  typedef t_tuser_seg [NUM_OF_SEG-1:0] t_tuser_seg_vec;

  t_arb_state          r_state;
  logic [CH_W-1:0]     r_cur_ch;
  logic [CH_W-1:0]     r_rr_ptr;
  logic [WEIGHT_W-1:0] r_burst_cnt;

  logic [NUM_CH-1:0]   w_elig;
  logic [15:0]         w_mask16;
  int                  w_scan_i;
  logic                w_stay;
  logic                w_any;
  logic [CH_W-1:0]     w_win;
  logic [CH_W-1:0]     w_sel;
  logic [WEIGHT_W-1:0] w_rr_weight;
  logic [WEIGHT_W-1:0] w_burst_nxt;
  logic                w_grant;
  logic                w_skid_ready;
  logic                w_accept;
  logic                w_sel_tlast;
  t_tuser_seg_vec      w_sel_tuser;
  logic [PW-1:0]       w_skid_in;
  logic [PW-1:0]       w_skid_out;

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_elig[ch] = i_in_tvalid[ch] && (i_ch_weight[ch*WEIGHT_W +: WEIGHT_W] != '0);
    end
    w_mask16 = '0;
    w_mask16[NUM_CH-1:0] = w_elig;
    w_rr_weight = i_ch_weight[r_rr_ptr*WEIGHT_W +: WEIGHT_W];
    // burst_cnt is only 0 straight out of reset; treating 0 as "no turn in
    // progress" lets the scan start past rr_ptr=NUM_CH-1 so ch0 wins first.
    w_stay   = w_elig[r_rr_ptr] && (r_burst_cnt != '0) && (r_burst_cnt < w_rr_weight);
    w_scan_i = next_eligible(w_mask16, int'(r_rr_ptr), NUM_CH);
    w_any    = w_stay || (w_scan_i >= 0);
    w_win    = w_stay ? r_rr_ptr : CH_W'(w_scan_i);
    if (!w_stay)
      w_burst_nxt = WEIGHT_W'(1);
    else if (r_burst_cnt == {WEIGHT_W{1'b1}})
      w_burst_nxt = r_burst_cnt;
    else
      w_burst_nxt = r_burst_cnt + 1'b1;

    // While locked the current channel keeps the grant even with tvalid low.
    w_sel   = (r_state == ARB_LOCKED) ? r_cur_ch : w_win;
    w_grant = (r_state == ARB_LOCKED) || w_any;
    o_in_tready = '0;
    if (w_grant) o_in_tready[w_sel] = w_skid_ready;
    w_accept    = w_grant && w_skid_ready && i_in_tvalid[w_sel];
    w_sel_tlast = i_in_tlast[w_sel];
    w_sel_tuser = i_in_tuser[w_sel*TUSER_W +: TUSER_W];
    w_skid_in   = {w_sel_tuser, w_sel_tlast,
                   i_in_tkeep[w_sel*TKEEP_WIDTH +: TKEEP_WIDTH],
                   i_in_tdata[w_sel*TDATA_WIDTH +: TDATA_WIDTH]};
  end

  always_ff @(posedge i_hip_clk or negedge i_hip_rst_n) begin
    if (!i_hip_rst_n) begin
      r_state     <= ARB_OPEN;
      r_cur_ch    <= '0;
      r_rr_ptr    <= CH_W'(NUM_CH - 1);
      r_burst_cnt <= '0;
    end else if (w_accept) begin
      case (r_state)
        ARB_OPEN: begin
          r_rr_ptr    <= w_win;
          r_burst_cnt <= w_burst_nxt;
          if (!w_sel_tlast) begin
            r_state  <= ARB_LOCKED;
            r_cur_ch <= w_win;
          end
        end
        ARB_LOCKED: begin
          if (w_sel_tlast) r_state <= ARB_OPEN;
        end
        default: r_state <= ARB_OPEN;
      endcase
    end
  end

  ofs_fim_pcie_ss_tx_arb_skid #(
    .PAYLOAD_W (PW)
  ) u_skid (
    .i_clk    (i_hip_clk),
    .i_rst_n  (i_hip_rst_n),
    .i_tvalid (w_accept),
    .o_tready (w_skid_ready),
    .i_tdata  (w_skid_in),
    .o_tvalid (o_out_tvalid),
    .i_tready (i_out_tready),
    .o_tdata  (w_skid_out)
  );

  assign o_out_tdata = w_skid_out[TDATA_WIDTH-1:0];
  assign o_out_tkeep = w_skid_out[TDATA_WIDTH +: TKEEP_WIDTH];
  assign o_out_tlast = w_skid_out[TDATA_WIDTH+TKEEP_WIDTH];
  assign o_out_tuser = w_skid_out[PW-1 -: TUSER_W];

`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
  logic [31:0] r_pkt_cnt [NUM_CH];

  always_ff @(posedge i_hip_clk or negedge i_hip_rst_n) begin
    if (!i_hip_rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) r_pkt_cnt[ch] <= '0;
    end else if (w_accept && w_sel_tlast) begin
      r_pkt_cnt[w_sel] <= r_pkt_cnt[w_sel] + 32'd1;
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) o_pkt_cnt[ch*32 +: 32] = r_pkt_cnt[ch];
  end
`else
  assign o_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_arb.sv
// tb/tb_ofs_fim_pcie_ss_tx_arb.sv - randomized scoreboard bench for ofs_fim_pcie_ss_tx_arb
module tb_ofs_fim_pcie_ss_tx_arb;
  import ofs_fim_pcie_ss_shims_pkg::*;

  localparam int NCH = 4;
  localparam int TW  = 512;
  localparam int KW  = TW / 8;
  localparam int WW  = 4;
  localparam int UW  = tuser_seg_vec_width(1);
`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NCH-1:0]     i_in_tvalid;
  logic [NCH-1:0]     o_in_tready;
  logic [NCH*TW-1:0]  i_in_tdata;
  logic [NCH*KW-1:0]  i_in_tkeep;
  logic [NCH-1:0]     i_in_tlast;
  logic [NCH*UW-1:0]  i_in_tuser;
  logic [NCH*WW-1:0]  i_ch_weight;
  logic               o_out_tvalid;
  logic               i_out_tready;
  logic [TW-1:0]      o_out_tdata;
  logic [KW-1:0]      o_out_tkeep;
  logic               o_out_tlast;
  logic [UW-1:0]      o_out_tuser;
  logic [NCH*32-1:0]  o_pkt_cnt;

  always #5 clk = ~clk;

  ofs_fim_pcie_ss_tx_arb #(
    .NUM_CH(NCH), .TDATA_WIDTH(TW), .TKEEP_WIDTH(KW), .NUM_OF_SEG(1), .WEIGHT_W(WW)
  ) dut (
    .i_hip_clk(clk), .i_hip_rst_n(rst_n),
    .i_in_tvalid(i_in_tvalid), .o_in_tready(o_in_tready),
    .i_in_tdata(i_in_tdata), .i_in_tkeep(i_in_tkeep), .i_in_tlast(i_in_tlast),
    .i_in_tuser(i_in_tuser), .i_ch_weight(i_ch_weight),
    .o_out_tvalid(o_out_tvalid), .i_out_tready(i_out_tready),
    .o_out_tdata(o_out_tdata), .o_out_tkeep(o_out_tkeep), .o_out_tlast(o_out_tlast),
    .o_out_tuser(o_out_tuser), .o_pkt_cnt(o_pkt_cnt)
  );

  typedef struct {
    logic [TW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
    int            gap;
  } beat_t;

  beat_t tx_q  [NCH][$];
  beat_t exp_q [NCH][$];
  int    gap_left [NCH];
  int    pushed [NCH];
  int    wts [NCH];
  int    acc_cyc_q[$];
  int    ord_q[$];
  int    ord_cyc_q[$];
  int    n_chk = 0, n_fail = 0;
  int    cyc = 0, out_mode = 0;
  bit    lat_chk = 0, tog_chk = 0;
  int    out_ch = -1, in_lock = -1;
  int    n_viol = 0, n_dep = 0, n_spur = 0;
  int    t_last0 = -1, t_ch1 = -1;
  logic  prev_stall = 1'b0;
  logic [TW-1:0] prev_data;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int ch = 0; ch < NCH; ch++) n += exp_q[ch].size();
    return n;
  endfunction

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    wts[0] = w0; wts[1] = w1; wts[2] = w2; wts[3] = w3;
    for (int ch = 0; ch < NCH; ch++) i_ch_weight[ch*WW +: WW] = WW'(wts[ch]);
  endtask

  task automatic push_pkt(input int ch, input int len, input int gap_idx, input int gap_len);
    beat_t bt;
    logic [511:0] tmp;
    for (int b = 0; b < len; b++) begin
      for (int w = 0; w < TW/32; w++) bt.data[w*32 +: 32] = $urandom();
      bt.data[3:0] = 4'(ch);
      bt.keep = {$urandom(), $urandom()};
      for (int w = 0; w < 16; w++) tmp[w*32 +: 32] = $urandom();
      bt.user = tmp[UW-1:0];
      bt.last = (b == len - 1);
      bt.gap  = (b == gap_idx) ? gap_len : 0;
      if (tx_q[ch].size() == 0) gap_left[ch] = bt.gap;
      tx_q[ch].push_back(bt);
      exp_q[ch].push_back(bt);
    end
    pushed[ch]++;
  endtask

  task automatic drive(input logic [NCH-1:0] acc);
    beat_t bt;
    for (int ch = 0; ch < NCH; ch++) begin
      if (acc[ch]) begin
        bt = tx_q[ch].pop_front();
        i_in_tvalid[ch] = 1'b0;
        gap_left[ch] = (tx_q[ch].size() > 0) ? tx_q[ch][0].gap : 0;
      end
      if (!i_in_tvalid[ch] && tx_q[ch].size() > 0) begin
        if (gap_left[ch] > 0) gap_left[ch]--;
        else begin
          i_in_tvalid[ch] = 1'b1;
          i_in_tdata[ch*TW +: TW] = tx_q[ch][0].data;
          i_in_tkeep[ch*KW +: KW] = tx_q[ch][0].keep;
          i_in_tlast[ch]          = tx_q[ch][0].last;
          i_in_tuser[ch*UW +: UW] = tx_q[ch][0].user;
        end
      end
    end
    case (out_mode)
      0:       i_out_tready = 1'b1;
      1:       i_out_tready = ~i_out_tready;
      default: i_out_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic step();
    logic [NCH-1:0] acc;
    logic [NCH-1:0] rdy0;
    beat_t e;
    int ch, a;
    @(negedge clk);
    if (tog_chk) begin
      rdy0 = o_in_tready;
      i_out_tready = ~i_out_tready;
      #1;
      if (o_in_tready !== rdy0) n_dep++;
      i_out_tready = ~i_out_tready;
      #1;
    end
    cyc++;
    acc = o_in_tready & i_in_tvalid;
    if ($countones(o_in_tready) > 1) n_viol++;
    for (int c = 0; c < NCH; c++)
      if (o_in_tready[c] && in_lock >= 0 && c != in_lock) n_viol++;
    for (int c = 0; c < NCH; c++) begin
      if (acc[c]) begin
        acc_cyc_q.push_back(cyc);
        if (i_in_tlast[c]) begin
          in_lock = -1;
          if (c == 0) t_last0 = cyc;
        end else in_lock = c;
        if (c == 1 && t_ch1 < 0) t_ch1 = cyc;
      end
    end
    if (prev_stall) begin
      check_eq("hold_valid", o_out_tvalid, 1);
      check_eq("hold_data", o_out_tdata, prev_data);
    end
    if (o_out_tvalid && i_out_tready) begin
      ch = int'(o_out_tdata[3:0]);
      if (ch >= NCH || exp_q[ch % NCH].size() == 0) n_spur++;
      else begin
        e = exp_q[ch].pop_front();
        check_eq("out_data", o_out_tdata, e.data);
        check_eq("out_keep", o_out_tkeep, e.keep);
        check_eq("out_last", o_out_tlast, e.last);
        check_eq("out_user", o_out_tuser, e.user);
        if (out_ch < 0) begin
          ord_q.push_back(ch);
          ord_cyc_q.push_back(cyc);
        end else check_eq("pkt_atomic", ch, out_ch);
        out_ch = o_out_tlast ? -1 : ch;
      end
      if (acc_cyc_q.size() > 0) begin
        a = acc_cyc_q.pop_front();
        if (lat_chk) check_eq("latency", cyc - a, 1);
      end
    end
    prev_stall = o_out_tvalid & ~i_out_tready;
    prev_data  = o_out_tdata;
    @(posedge clk);
    #1;
    drive(acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_tvalid", o_out_tvalid, 0);
    check_eq("rst_in_tready", o_in_tready, 0);
    check_eq("rst_pkt_cnt", o_pkt_cnt, 0);
    for (int ch = 0; ch < NCH; ch++) begin
      tx_q[ch].delete();
      exp_q[ch].delete();
      gap_left[ch] = 0;
      pushed[ch] = 0;
    end
    acc_cyc_q.delete();
    ord_q.delete();
    ord_cyc_q.delete();
    in_lock = -1; out_ch = -1; prev_stall = 1'b0;
    t_last0 = -1; t_ch1 = -1;
    i_in_tvalid = '0;
    i_out_tready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_drain(input int budget, input string tag);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, pending(), 0);
  endtask

  task automatic run_until_ord(input int m, input int budget, input string tag);
    int n = 0;
    while (ord_q.size() < m && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, ord_q.size() >= m, 1);
  endtask

  // Reference grant order when every channel always has a 1-beat packet:
  // each round visits channels 0..NCH-1, granting each wts[ch] packets.
  task automatic check_order(input int m, input string tag);
    int exp_ord[$];
    while (exp_ord.size() < m)
      for (int ch = 0; ch < NCH; ch++)
        for (int k = 0; k < wts[ch]; k++) exp_ord.push_back(ch);
    for (int i = 0; i < m && i < ord_q.size(); i++) check_eq(tag, ord_q[i], exp_ord[i]);
    if (ord_q.size() >= m) check_eq({tag, "_no_idle"}, ord_cyc_q[m-1] - ord_cyc_q[0], m - 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_in_tvalid = '0; i_in_tdata = '0; i_in_tkeep = '0; i_in_tlast = '0; i_in_tuser = '0;
    i_out_tready = 1'b1;
    set_weights(1, 1, 1, 1);
    repeat (2) @(posedge clk);

    // 3-beat packet on ch0: 1-cycle latency, bit-exact payload.
    do_reset();
    out_mode = 0; lat_chk = 1;
    push_pkt(0, 3, -1, 0);
    run_drain(50, "t1_drain");
    check_eq("t1_pkts", ord_q.size(), 1);

    // Equal weights, all channels streaming single-beat packets.
    do_reset();
    set_weights(1, 1, 1, 1);
    for (int ch = 0; ch < NCH; ch++) repeat (6) push_pkt(ch, 1, -1, 0);
    run_until_ord(12, 100, "t2_count");
    check_order(12, "t2_order");

    do_reset();
    set_weights(2, 1, 1, 1);
    for (int ch = 0; ch < NCH; ch++) repeat (12) push_pkt(ch, 1, -1, 0);
    run_until_ord(8, 100, "t3_count");
    check_order(8, "t3_order");

    do_reset();
    set_weights(2, 1, 0, 1);
    for (int ch = 0; ch < NCH; ch++) repeat (12) push_pkt(ch, 1, -1, 0);
    run_until_ord(6, 100, "t3m_count");
    check_order(6, "t3m_order");

    // ch0 4-beat packet with a tvalid gap after beat 2; ch1 waits, no bubble after.
    do_reset();
    set_weights(1, 1, 1, 1);
    push_pkt(0, 4, 2, 3);
    push_pkt(1, 1, -1, 0);
    run_drain(60, "t4_drain");
    check_eq("t4_no_bubble", t_ch1, t_last0 + 1);
    if (ord_q.size() >= 2) begin
      check_eq("t4_first", ord_q[0], 0);
      check_eq("t4_second", ord_q[1], 1);
    end else check_eq("t4_pkts", ord_q.size(), 2);

    // 100 random packets under alternating backpressure.
    do_reset();
    lat_chk = 0; tog_chk = 1; out_mode = 1;
    set_weights($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3));
    for (int p = 0; p < 100; p++) begin
      int len;
      len = $urandom_range(1, 4);
      push_pkt($urandom_range(0, NCH - 1), len, $urandom_range(0, len - 1), $urandom_range(0, 2));
    end
    run_drain(5000, "t5_drain");
    repeat (3) step();
    for (int ch = 0; ch < NCH; ch++)
      check_eq("t5_pkt_cnt", o_pkt_cnt[ch*32 +: 32], STATS_EN ? pushed[ch] : 0);
    tog_chk = 0; out_mode = 0;

    // Reset mid-packet, then ch0 wins first.
    do_reset();
    push_pkt(0, 6, -1, 0);
    repeat (3) step();
    do_reset();
    lat_chk = 1;
    for (int ch = 0; ch < NCH; ch++) push_pkt(ch, 1, -1, 0);
    run_until_ord(1, 50, "t6_count");
    if (ord_q.size() > 0) check_eq("t6_first_ch", ord_q[0], 0);
    run_drain(50, "t6_drain");

    // Packet statistics.
    do_reset();
    repeat (5) push_pkt(2, $urandom_range(1, 3), -1, 0);
    run_drain(100, "t7_drain");
    repeat (2) step();
    for (int ch = 0; ch < NCH; ch++)
      check_eq("t7_pkt_cnt", o_pkt_cnt[ch*32 +: 32], (STATS_EN && ch == 2) ? 5 : 0);

    check_eq("in_lock_violations", n_viol, 0);
    check_eq("tready_from_out_tready", n_dep, 0);
    check_eq("spurious_out", n_spur, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
